// File: rtl/dct_pkg.sv
// Shared definitions for the distributed-arithmetic 8-point DCT engine:
// FSM encoding, fractional-width derivation and the cosine coefficient tables.
package dct_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BFLY,
        CALC,
        OUT
    } state_t;

    function automatic int frac_w(input int coef_w);
        frac_w = coef_w - 2;
    endfunction

    // c(k,n) for COEF_W = 16, rounded half away from zero so even-k rows cancel exactly
    localparam int COEF16 [8][4] = '{
        '{ 5793,  5793,  5793,  5793},
        '{ 8035,  6811,  4551,  1598},
        '{ 7568,  3135, -3135, -7568},
        '{ 6811, -1598, -8035, -4551},
        '{ 5793, -5793, -5793,  5793},
        '{ 4551, -8035,  1598,  6811},
        '{ 3135, -7568,  7568, -3135},
        '{ 1598, -4551,  6811, -8035}
    };

    // Elaboration-time generator; other widths fold the angle into the first
    // quadrant and evaluate cos with a Taylor series before symmetric rounding.
    function automatic int coef_val(input int coef_w, input int k, input int n);
        int  m;
        int  sgn;
        real x;
        real term;
        real sum;
        real scale;
        if (coef_w == 16) begin
            coef_val = COEF16[k][n];
        end else begin
            m   = ((2 * n + 1) * k) % 32;
            sgn = 1;
            if (m > 16) m = 32 - m;
            if (m > 8) begin
                m   = 16 - m;
                sgn = -1;
            end
            x    = real'(m) * 3.14159265358979323846 / 16.0;
            term = 1.0;
            sum  = 1.0;
            for (int i = 1; i < 12; i++) begin
                term = -term * x * x / real'((2 * i - 1) * (2 * i));
                sum  = sum + term;
            end
            scale = 0.5 * sum;
            if (k == 0) scale = scale * 0.70710678118654752;
            for (int i = 0; i < coef_w - 2; i++) scale = scale * 2.0;
            coef_val = sgn * $rtoi(scale + 0.5);
        end
    endfunction

    function automatic int rom_entry(input int coef_w, input int k, input int a);
        rom_entry = 0;
        for (int n = 0; n < 4; n++) begin
            if (((a >> n) & 1) != 0) rom_entry = rom_entry + coef_val(coef_w, k, n);
        end
    endfunction

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

endpackage

// File: rtl/dct8_coef_rom.sv
// Distributed-arithmetic partial-sum ROM: entry[k][a] is the sum of c(k,n)
// over the set bits n of a. Registered output, one cycle of latency.
module dct8_coef_rom
    import dct_pkg::*;
#(
    parameter int COEF_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               k_i,
    input  logic [3:0]               addr_i,
    output logic signed [COEF_W+1:0] entry_o
);

    localparam int ROM_W = COEF_W + 2;

    logic signed [ROM_W-1:0] table_w [128];
    logic signed [ROM_W-1:0] entry_q;

    for (genvar g = 0; g < 128; g++) begin : g_entry
        localparam int VALUE = rom_entry(COEF_W, g / 16, g % 16);
        assign table_w[g] = ROM_W'(VALUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= table_w[{k_i, addr_i}];
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/dct8_da_engine.sv
// Time-multiplexed 8-point 1-D DCT using bit-serial distributed arithmetic.
// Optional build macro DCT_ROUND_EN rounds results to integer instead of full precision.
module dct8_da_engine
    import dct_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int OUT_W  = DATA_W + COEF_W + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_W-1:0]     in_x,
    input  logic [7:0]              in_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [2:0]              out_idx,
    output logic                    out_last
);

    localparam int B     = DATA_W + 1;
    localparam int ROM_W = COEF_W + 2;
    localparam int ACC_W = DATA_W + COEF_W + 3;
    localparam int CNT_W = $clog2(B + 1);

    if (OUT_W < DATA_W + COEF_W + 3) begin : g_out_w_check
        $error("dct8_da_engine: OUT_W must be at least DATA_W+COEF_W+3");
    end

    state_t                  state_q;
    logic [8*DATA_W-1:0]     x_q;
    logic [7:0]              mask_q;
    logic signed [B-1:0]     s_q [4];
    logic signed [B-1:0]     d_q [4];
    logic [2:0]              k_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [2:0]              out_idx_q;
    logic signed [OUT_W-1:0] out_data_q;

    logic signed [DATA_W-1:0] xs [8];
    logic [3:0]               addr_d;
    logic [CNT_W-1:0]         bit_idx;
    logic signed [ROM_W-1:0]  rom_q;
    logic signed [ACC_W-1:0]  rom_ext;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [OUT_W-1:0]  result_d;
    logic [2:0]               next_k;
    logic [7:0]               mask_clr;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            xs[i] = x_q[i*DATA_W +: DATA_W];
        end
        next_k   = lowest_bit(mask_q);
        mask_clr = mask_q & ~(8'd1 << next_k);
    end

    // Cycle cnt of CALC addresses bit B-1-cnt; the ROM answers one cycle later.
    always_comb begin
        addr_d  = '0;
        bit_idx = CNT_W'(B - 1) - cnt_q;
        if (cnt_q < CNT_W'(B)) begin
            for (int n = 0; n < 4; n++) begin
                addr_d[n] = k_q[0] ? d_q[n][bit_idx] : s_q[n][bit_idx];
            end
        end
    end

    always_comb begin
        rom_ext = ACC_W'(rom_q);
        if (cnt_q == CNT_W'(1)) begin
            acc_d = -rom_ext;
        end else begin
            acc_d = (acc_q <<< 1) + rom_ext;
        end
    end

`ifdef DCT_ROUND_EN
    localparam int                FRAC_W = frac_w(COEF_W);
    localparam int                RND_W  = ACC_W + 1;
    localparam logic signed [ACC_W:0] HALF = RND_W'(1) <<< (FRAC_W - 1);

    logic signed [ACC_W:0] rnd_d;

    always_comb begin
        rnd_d    = RND_W'(acc_d) + HALF;
        result_d = OUT_W'(rnd_d >>> FRAC_W);
    end
`else
    always_comb begin
        result_d = OUT_W'(acc_d);
    end
`endif

    dct8_coef_rom #(
        .COEF_W (COEF_W)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .k_i     (k_q),
        .addr_i  (addr_d),
        .entry_o (rom_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            mask_q      <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                s_q[i] <= '0;
                d_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_x;
                        mask_q  <= in_mask;
                        state_q <= BFLY;
                    end
                end
                BFLY: begin
                    for (int i = 0; i < 4; i++) begin
                        s_q[i] <= B'(xs[i]) + B'(xs[7-i]);
                        d_q[i] <= B'(xs[i]) - B'(xs[7-i]);
                    end
                    if (mask_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        k_q     <= next_k;
                        mask_q  <= mask_clr;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q != '0) acc_q <= acc_d;
                    if (cnt_q == CNT_W'(B)) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= result_d;
                        out_idx_q   <= k_q;
                        out_last_q  <= (mask_q == 8'd0);
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (mask_q != 8'd0) begin
                            k_q     <= next_k;
                            mask_q  <= mask_clr;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct8_da_engine.sv
// Self-checking bench for dct8_da_engine with a direct dot-product reference model.
// Honours the DCT_ROUND_EN build macro when forming expected results.
module tb_dct8_da_engine;

    localparam int DATA_W = 8;
    localparam int COEF_W = 16;
    localparam int OUT_W  = DATA_W + COEF_W + 3;
    localparam int B      = DATA_W + 1;

    localparam int C [8][4] = '{
        '{ 5793,  5793,  5793,  5793},
        '{ 8035,  6811,  4551,  1598},
        '{ 7568,  3135, -3135, -7568},
        '{ 6811, -1598, -8035, -4551},
        '{ 5793, -5793, -5793,  5793},
        '{ 4551, -8035,  1598,  6811},
        '{ 3135, -7568,  7568, -3135},
        '{ 1598, -4551,  6811, -8035}
    };

    typedef struct {
        logic signed [63:0] data;
        int                 idx;
        logic               last;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [8*DATA_W-1:0]     in_x;
    logic [7:0]              in_mask;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [2:0]              out_idx;
    logic                    out_last;

    exp_t sb[$];
    int   xs [8];
    int   compared   = 0;
    int   mismatched = 0;

    dct8_da_engine #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic signed [63:0] modelCoef(input int k);
        longint sum;
        longint op;
        sum = 0;
        for (int n = 0; n < 4; n++) begin
            op  = (k % 2 == 1) ? longint'(xs[n] - xs[7-n]) : longint'(xs[n] + xs[7-n]);
            sum = sum + longint'(C[k][n]) * op;
        end
`ifdef DCT_ROUND_EN
        sum = (sum + 64'sd8192) >>> 14;
`endif
        return sum;
    endfunction

    task automatic applyStimulus(input logic [7:0] mask);
        int   waited;
        int   highest;
        exp_t e;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("in_ready_before_offer", in_ready, 1);
        for (int i = 0; i < 8; i++) in_x[i*DATA_W +: DATA_W] = DATA_W'(xs[i]);
        in_mask  = mask;
        in_valid = 1'b1;
        highest  = -1;
        for (int k = 0; k < 8; k++) if (mask[k]) highest = k;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
                e.data = modelCoef(k);
                e.idx  = k;
                e.last = (k == highest);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int drained;
        drained = 0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && in_ready) begin
                drained = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("drain_complete", drained, 1);
    endtask

    // Scoreboard pops on every handshake seen on the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput($sformatf("data_k%0d", e.idx), out_data, e.data);
                checkOutput($sformatf("idx_k%0d", e.idx), out_idx, e.idx);
                checkOutput($sformatf("last_k%0d", e.idx), out_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        int firstValid;
        int doneAt;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_mask   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_idx", out_idx, 0);
        checkOutput("reset_out_last", out_last, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] all-ones block, full mask");
        xs = '{1, 1, 1, 1, 1, 1, 1, 1};
        applyStimulus(8'hFF);
        firstValid = -1;
        doneAt     = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && firstValid < 0) firstValid = i;
            if (in_ready) begin
                doneAt = i;
                break;
            end
        end
        checkOutput("first_valid_latency", firstValid, B + 2);
        checkOutput("full_mask_busy_cycles", doneAt, 8 * (B + 2) + 1);
        waitDrain();

        $display("[TB] impulse on x0, mask 0x03");
        xs = '{100, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(8'h03);
        waitDrain();

        $display("[TB] all -128, mask 0x01");
        xs = '{-128, -128, -128, -128, -128, -128, -128, -128};
        applyStimulus(8'h01);
        waitDrain();

        $display("[TB] empty mask");
        xs = '{3, 4, 5, 6, 7, 8, 9, 10};
        applyStimulus(8'h00);
        doneAt = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) begin
                doneAt = i;
                break;
            end
        end
        checkOutput("mask0_ready_latency", doneAt, 0 * (B + 2) + 1);
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] backpressure with ignored offer");
        xs = '{5, -3, 77, -128, 127, 0, -60, 33};
        out_ready = 1'b0;
        applyStimulus(8'h2C);
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("stall_reached_out", out_valid, 1);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                in_x     = {8{8'h55}};
                in_mask  = 8'hFF;
                in_valid = 1'b1;
            end
            if (c == 9) in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                checkOutput("stall_data", out_data, sb[0].data);
                checkOutput("stall_idx", out_idx, sb[0].idx);
                checkOutput("stall_last", out_last, sb[0].last);
            end
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        repeat (30) @(posedge clk);
        #1;
        checkOutput("post_stall_idle", in_ready, 1);

        $display("[TB] reset during CALC of k=3");
        xs = '{10, -20, 30, -40, 50, -60, 70, -80};
        applyStimulus(8'h0F);
        for (int i = 0; i < 200 && sb.size() > 1; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reached_k3", sb.size(), 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_out_data", out_data, 0);
        checkOutput("abort_out_idx", out_idx, 0);
        checkOutput("abort_out_last", out_last, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("post_abort_quiet", out_valid, 0);
        xs = '{1, 1, 1, 1, 1, 1, 1, 1};
        applyStimulus(8'h01);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
